servant_arbiter_rr: RTL and testbench

Parametrised N-master Wishbone arbiter for the servant SoC, the successor to the fixed two-master ibus/dbus arbiter. It grants one master at a time onto a single shared slave port using round-robin priority, and holds each grant until the slave acks. A watchdog terminates a stalled transfer so that the serv core can never hang on a missing ack. It sits between the CPU buses (plus optional DMA or accelerator masters) and `servant_ram`.

---
 rtl/servant_arbiter_rr_pkg.sv | 26 ++
 rtl/servant_rr_pick.sv | 41 ++++
 rtl/servant_arbiter_rr.sv | 163 ++++++++++++++++
 tb/tb_servant_arbiter_rr.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/servant_arbiter_rr_pkg.sv
// servant_arbiter_rr_pkg
// Shared helper functions for the round-robin Wishbone arbiter and its
// request picker. It has no ports. It holds constant-safe helpers for
// index width and modulo increment, so that every user of the picker
// agrees on how indices are sized and wrapped.
package servant_arbiter_rr_pkg;

  // Width needed to hold values 0..v-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned v);
    if (v <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(v);
    end
  endfunction

  // (v + 1) mod n without a divider; v is assumed to be below n.
  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    if (v + 32'd1 >= n) begin
      return 32'd0;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/servant_rr_pick.sv
// servant_rr_pick
// Combinational round-robin picker. It returns the first set bit of the
// request vector, scanning upward from a start pointer and wrapping modulo N.
// The DMA arbiters reuse it.
//   req_i   : N-bit request vector
//   ptr_i   : index at which the scan starts (highest priority)
//   valid_o : at least one request is set
//   idx_o   : index of the selected requester (0 when valid_o is low)
module servant_rr_pick
  import servant_arbiter_rr_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic             found_s;
  logic [IDX_W-1:0] cand_s;

  // Scan candidates in priority order; the first hit wins.
  always_comb begin
    found_s = 1'b0;
    cand_s  = '0;
    idx_o   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand_s = IDX_W'((32'(ptr_i) + i) % N);
      if (!found_s && req_i[cand_s]) begin
        found_s = 1'b1;
        idx_o   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    valid_o = found_s;
  end

endmodule

// File: rtl/servant_arbiter_rr.sv
// servant_arbiter_rr
// N-master Wishbone arbiter with round-robin priority. One master at a time is
// granted onto a single slave port. A grant is held until the slave acks, the
// master aborts, or the watchdog expires.
//   i_wb_clk, i_wb_rst         : clock, synchronous active-high reset
//   i_wb_m_adr/dat/sel/we/cyc  : flattened master buses, master k in slice k
//   o_wb_m_rdt, o_wb_m_ack     : shared read data, per-master ack
//   o_wb_s_adr/dat/sel/we/cyc  : slave port driven by the granted master
//   i_wb_s_rdt, i_wb_s_ack     : slave read data and ack
//   o_grant                    : one-hot grant, zero while idle
//   o_timeout                  : one-cycle pulse when the watchdog ends a transfer
module servant_arbiter_rr
  import servant_arbiter_rr_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned ADR_WIDTH   = 32,
  parameter int unsigned DAT_WIDTH   = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                               i_wb_clk,
  input  logic                               i_wb_rst,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0]   i_wb_m_adr,
  input  logic [NUM_MASTERS*DAT_WIDTH-1:0]   i_wb_m_dat,
  input  logic [NUM_MASTERS*DAT_WIDTH/8-1:0] i_wb_m_sel,
  input  logic [NUM_MASTERS-1:0]             i_wb_m_we,
  input  logic [NUM_MASTERS-1:0]             i_wb_m_cyc,
  output logic [DAT_WIDTH-1:0]               o_wb_m_rdt,
  output logic [NUM_MASTERS-1:0]             o_wb_m_ack,
  output logic [ADR_WIDTH-1:0]               o_wb_s_adr,
  output logic [DAT_WIDTH-1:0]               o_wb_s_dat,
  output logic [DAT_WIDTH/8-1:0]             o_wb_s_sel,
  output logic                               o_wb_s_we,
  output logic                               o_wb_s_cyc,
  input  logic [DAT_WIDTH-1:0]               i_wb_s_rdt,
  input  logic                               i_wb_s_ack,
  output logic [NUM_MASTERS-1:0]             o_grant,
  output logic                               o_timeout
);

  localparam int unsigned IDX_W   = clog2_min1(NUM_MASTERS);
  localparam int unsigned SEL_W   = DAT_WIDTH / 8;
  localparam int unsigned CNT_W   = clog2_min1(TIMEOUT + 32'd1);
  localparam int unsigned TO_LAST = (TIMEOUT == 32'd0) ? 32'd0 : TIMEOUT - 32'd1;
  localparam bit          WD_EN   = (TIMEOUT != 32'd0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             pick_valid_s;
  logic [IDX_W-1:0] pick_idx_s;
  logic [IDX_W-1:0] ptr_next_s;
  logic             busy_s;
  logic             gnt_cyc_s;
  logic             cnt_hit_s;
  logic             ack_fire_s;
  logic             to_fire_s;

  servant_rr_pick #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_pick (
    .req_i   (i_wb_m_cyc),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid_s),
    .idx_o   (pick_idx_s)
  );

  assign busy_s     = (state_q == ST_BUSY);
  assign gnt_cyc_s  = i_wb_m_cyc[gnt_q];
  assign cnt_hit_s  = WD_EN && (cnt_q == CNT_W'(TO_LAST));
  assign ptr_next_s = IDX_W'(wrap_inc(32'(gnt_q), NUM_MASTERS));

  // A real ack takes priority over the watchdog. While reset is asserted the
  // transfer is dropped, so no ack is forwarded in that cycle.
  assign ack_fire_s = busy_s && i_wb_s_ack && !i_wb_rst;
  assign to_fire_s  = busy_s && cnt_hit_s && !i_wb_s_ack && !i_wb_rst;

  // State, grant, pointer and watchdog registers.
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: arbitrate in IDLE, wait for ack/timeout/abort in BUSY.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          gnt_d   = pick_idx_s;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (i_wb_s_ack) begin
          ptr_d   = ptr_next_s;
          state_d = ST_IDLE;
        end else if (cnt_hit_s) begin
          ptr_d   = ptr_next_s;
          state_d = ST_IDLE;
        end else if (!gnt_cyc_s) begin
          // An abort leaves the pointer alone, so the master keeps its turn.
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(32'd1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Per-master ack and one-hot grant decoding.
  always_comb begin
    o_wb_m_ack = '0;
    o_grant    = '0;
    if (ack_fire_s || to_fire_s) begin
      o_wb_m_ack[gnt_q] = 1'b1;
    end else begin
      o_wb_m_ack = '0;
    end
    if (busy_s) begin
      o_grant[gnt_q] = 1'b1;
    end else begin
      o_grant = '0;
    end
  end

  assign o_wb_m_rdt = to_fire_s ? '0 : i_wb_s_rdt;
  assign o_timeout  = to_fire_s;

  // The slave port always shows the granted master's request. cyc is
  // qualified so that an aborting master releases the slave in the same cycle.
  assign o_wb_s_cyc = busy_s && gnt_cyc_s;
  assign o_wb_s_adr = i_wb_m_adr[gnt_q*ADR_WIDTH +: ADR_WIDTH];
  assign o_wb_s_dat = i_wb_m_dat[gnt_q*DAT_WIDTH +: DAT_WIDTH];
  assign o_wb_s_sel = i_wb_m_sel[gnt_q*SEL_W +: SEL_W];
  assign o_wb_s_we  = i_wb_m_we[gnt_q];

endmodule

// File: tb/tb_servant_arbiter_rr.sv
// tb_servant_arbiter_rr
// Directed self-checking bench for servant_arbiter_rr with 4 masters and
// TIMEOUT=4. Inputs change 1 time unit after the rising edge. Outputs are
// sampled 1 time unit after that.
module tb_servant_arbiter_rr;

  localparam int unsigned NM = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [NM*SW-1:0]  m_sel;
  logic [NM-1:0]     m_we;
  logic [NM-1:0]     m_cyc;
  logic [DW-1:0]     m_rdt;
  logic [NM-1:0]     m_ack;
  logic [AW-1:0]     s_adr;
  logic [DW-1:0]     s_dat;
  logic [SW-1:0]     s_sel;
  logic              s_we;
  logic              s_cyc;
  logic [DW-1:0]     s_rdt;
  logic              s_ack;
  logic [NM-1:0]     grant;
  logic              timeout;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_order [5];

  always #5 clk = ~clk;

  servant_arbiter_rr #(
    .NUM_MASTERS (NM),
    .ADR_WIDTH   (AW),
    .DAT_WIDTH   (DW),
    .TIMEOUT     (TO)
  ) dut (
    .i_wb_clk   (clk),
    .i_wb_rst   (rst),
    .i_wb_m_adr (m_adr),
    .i_wb_m_dat (m_dat),
    .i_wb_m_sel (m_sel),
    .i_wb_m_we  (m_we),
    .i_wb_m_cyc (m_cyc),
    .o_wb_m_rdt (m_rdt),
    .o_wb_m_ack (m_ack),
    .o_wb_s_adr (s_adr),
    .o_wb_s_dat (s_dat),
    .o_wb_s_sel (s_sel),
    .o_wb_s_we  (s_we),
    .o_wb_s_cyc (s_cyc),
    .i_wb_s_rdt (s_rdt),
    .i_wb_s_ack (s_ack),
    .o_grant    (grant),
    .o_timeout  (timeout)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_order[0] = 4'b0001;
    exp_order[1] = 4'b0010;
    exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000;
    exp_order[4] = 4'b0001;

    rst   = 1'b1;
    m_cyc = 4'b0000;
    m_we  = 4'b0101;
    s_ack = 1'b0;
    s_rdt = 32'h0000_0000;
    for (int k = 0; k < NM; k++) begin
      m_adr[k*AW +: AW] = 32'h1000_0000 | (32'(k) << 8);
      m_dat[k*DW +: DW] = 32'hA000_0000 | 32'(k);
      m_sel[k*SW +: SW] = 4'b0001 << k;
    end
    adv();
    adv();
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_grant", grant, 4'b0000);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_m_ack", m_ack, 4'b0000);
    chk("rst_timeout", timeout, 1'b0);

    // Single master 0: one arbitration cycle, then a 1-cycle slave ack
    m_cyc = 4'b0001;
    #1;
    chk("t1_arb_s_cyc", s_cyc, 1'b0);
    adv();
    chk("t1_s_cyc", s_cyc, 1'b1);
    chk("t1_grant", grant, 4'b0001);
    chk("t1_s_adr", s_adr, 32'h1000_0000);
    chk("t1_s_dat", s_dat, 32'hA000_0000);
    chk("t1_s_sel", s_sel, 4'b0001);
    chk("t1_s_we", s_we, 1'b1);
    chk("t1_no_ack_yet", m_ack, 4'b0000);
    adv();
    s_ack = 1'b1;
    s_rdt = 32'hDEAD_BEEF;
    #1;
    chk("t1_ack", m_ack, 4'b0001);
    chk("t1_rdt", m_rdt, 32'hDEAD_BEEF);
    chk("t1_timeout", timeout, 1'b0);
    adv();
    s_ack = 1'b0;
    m_cyc = 4'b0000;
    #1;
    chk("t1_idle_grant", grant, 4'b0000);

    // Reset while idle returns the pointer to 0
    rst = 1'b1;
    adv();
    rst = 1'b0;

    // All four masters request with immediate acks: order 0,1,2,3,0
    m_cyc = 4'b1111;
    s_ack = 1'b1;
    s_rdt = 32'h0000_0000;
    #1;
    chk("t2_idle_ack_ignored", m_ack, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      adv();
      chk($sformatf("t2_grant%0d", i), grant, exp_order[i]);
      chk($sformatf("t2_ack%0d", i), m_ack, exp_order[i]);
      adv();
      chk($sformatf("t2_gap%0d", i), grant, 4'b0000);
    end
    m_cyc = 4'b0000;

    // Master 1 alone moves the pointer to 2, then masters 1 and 3 request
    m_cyc = 4'b0010;
    adv();
    chk("t3_pre_grant", grant, 4'b0010);
    chk("t3_pre_ack", m_ack, 4'b0010);
    adv();
    m_cyc = 4'b1010;
    #1;
    chk("t3_idle", grant, 4'b0000);
    adv();
    chk("t3_first_grant", grant, 4'b1000);
    chk("t3_first_ack", m_ack, 4'b1000);
    chk("t3_first_adr", s_adr, 32'h1000_0300);
    chk("t3_first_sel", s_sel, 4'b1000);
    adv();
    chk("t3_gap", grant, 4'b0000);
    adv();
    chk("t3_second_grant", grant, 4'b0010);
    chk("t3_second_ack", m_ack, 4'b0010);
    chk("t3_second_we", s_we, 1'b0);
    adv();
    m_cyc = 4'b0000;
    s_ack = 1'b0;

    // Watchdog: master 2, slave silent, pulse in the 4th BUSY cycle
    m_cyc = 4'b0100;
    adv();
    chk("t4_s_cyc", s_cyc, 1'b1);
    chk("t4_grant", grant, 4'b0100);
    chk("t4_to_early0", timeout, 1'b0);
    adv();
    adv();
    chk("t4_ack_early2", m_ack, 4'b0000);
    chk("t4_to_early2", timeout, 1'b0);
    adv();
    s_rdt = 32'h1234_5678;
    #1;
    chk("t4_ack", m_ack, 4'b0100);
    chk("t4_timeout", timeout, 1'b1);
    chk("t4_rdt_zero", m_rdt, 32'h0000_0000);
    adv();
    chk("t4_after_s_cyc", s_cyc, 1'b0);
    chk("t4_after_timeout", timeout, 1'b0);
    chk("t4_after_ack", m_ack, 4'b0000);
    chk("t4_after_rdt", m_rdt, 32'h1234_5678);
    m_cyc = 4'b0000;

    // Ack arriving in the watchdog cycle is a normal ack (pointer now 3)
    m_cyc = 4'b1000;
    adv();
    adv();
    adv();
    adv();
    s_ack = 1'b1;
    #1;
    chk("t5_ack", m_ack, 4'b1000);
    chk("t5_no_timeout", timeout, 1'b0);
    chk("t5_rdt", m_rdt, 32'h1234_5678);
    adv();
    s_ack = 1'b0;
    m_cyc = 4'b0000;

    // Abort: master 0 drops cyc mid-transfer, pointer stays at 0
    m_cyc = 4'b0001;
    adv();
    chk("t6_s_cyc", s_cyc, 1'b1);
    m_cyc = 4'b0000;
    #1;
    chk("t6_drop_s_cyc", s_cyc, 1'b0);
    chk("t6_drop_ack", m_ack, 4'b0000);
    adv();
    chk("t6_idle_grant", grant, 4'b0000);
    m_cyc = 4'b0011;
    adv();
    chk("t6_ptr_kept", grant, 4'b0001);

    // Reset for one cycle mid-BUSY with an ack pending
    s_ack = 1'b1;
    rst   = 1'b1;
    adv();
    rst = 1'b0;
    #1;
    chk("t7_ack", m_ack, 4'b0000);
    chk("t7_grant", grant, 4'b0000);
    chk("t7_s_cyc", s_cyc, 1'b0);
    chk("t7_timeout", timeout, 1'b0);
    adv();
    chk("t7_rearb_grant", grant, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
